// File: rtl/popcount_sched_if.sv
// Bundles the two requester channels, the result channel and the busy flag of popcount_sched.
// The slave modport is the counter's view. The master modport is the view of the requesters and the result consumer.
interface popcount_sched_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        res_valid;
  logic [5:0]  res_count;
  logic        res_id;
  logic        res_ready;
  logic        busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, res_valid, res_count, res_id, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, res_valid, res_count, res_id, busy
  );
endinterface

// File: rtl/popcount_sched.sv
// Two-requester population counter.
// A round-robin arbiter accepts one 32-bit word at a time.
// One shared 8-bit ones-counter then walks the four bytes over four RUN cycles.
// The result is held in DONE until the consumer takes it.
module popcount_sched (
  input  logic             clk,
  input  logic             rst,
  popcount_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [5:0]  acc_q, acc_d;
  logic [1:0]  idx_q, idx_d;
  logic        id_q, id_d;
  logic        last_grant_q, last_grant_d;

  logic        gnt0, gnt1;
  logic [7:0]  word_bytes [4];
  logic [7:0]  byte_sel;
  logic [3:0]  byte_ones;

  // Split the latched word into byte lanes so the running index can pick one lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
    assign word_bytes[gi] = word_q[gi*8 +: 8];
  end

  // Round-robin grant. Only in IDLE, and only to a valid requester.
  // When both are valid, the requester that did not win last time is served.
  always_comb begin
    gnt0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || last_grant_q);
    gnt1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
  end

  // The shared ones-counter, applied to the byte selected by the index.
  always_comb begin
    byte_sel  = word_bytes[idx_q];
    byte_ones = '0;
    for (int i = 0; i < 8; i++) begin
      byte_ones = byte_ones + {3'b000, byte_sel[i]};
    end
  end

  // Next-state logic: IDLE accepts a word, RUN accumulates one byte per cycle, DONE waits for the consumer.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          word_d       = gnt1 ? bus.req1_data : bus.req0_data;
          id_d         = gnt1;
          last_grant_d = gnt1;
          acc_d        = '0;
          idx_d        = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        // The sum is at most 32, so the 6-bit accumulator never wraps.
        acc_d = acc_q + {2'b00, byte_ones};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset. Reset also discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the pre-reset state.
  always_comb begin
    bus.req0_ready = gnt0 && !rst;
    bus.req1_ready = gnt1 && !rst;
    bus.res_valid  = (state_q == DONE) && !rst;
    bus.res_count  = rst ? 6'd0 : acc_q;
    bus.res_id     = id_q && !rst;
    bus.busy       = (state_q != IDLE) && !rst;
  end

endmodule

// File: doc/popcount_sched.md
POPCOUNT_SCHED -- requirements
Module: popcount_sched

Interface
REQ-001 Parameters: none; word width is fixed at 32 bits, processed as 4 bytes by one shared 8-bit ones-counter.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a word to count.
REQ-005 req0_data  input  32  requester 0 word; sampled only on the req0 handshake.
REQ-006 req0_ready  output  1  grant/accept for requester 0.
REQ-007 req1_valid, req1_data, req1_ready  same widths/meanings as REQ-004..006 for requester 1.
REQ-008 res_valid  output  1  result available.
REQ-009 res_count  output  6  number of ones in the accepted word, 0..32.
REQ-010 res_id  output  1  requester index that owns the result.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-014 reqN_ready is asserted only in IDLE, only when reqN_valid=1, and only for the granted requester; at most one ready is high in any cycle.
REQ-015 Arbitration, when both valid in IDLE: grant the requester not granted at the most recent handshake (round-robin); when only one is valid, grant it.
REQ-016 last_grant resets to 1, so requester 0 wins the first contention after reset.
REQ-017 Handshake (reqN_valid & reqN_ready) in cycle N: latch the data word, set res_id=N's index, clear the 6-bit accumulator, clear the 2-bit byte index, and update last_grant; the state becomes RUN.
REQ-018 Each RUN cycle: the accumulator adds the ones count of byte[idx] (idx 0 = bits 7:0), then idx increments.
REQ-019 The RUN cycle with idx=3 transitions to DONE; RUN lasts exactly 4 cycles.
REQ-020 Latency: handshake in cycle N produces res_valid=1 from cycle N+5.
REQ-021 The accumulator is 6 bits wide; the maximum value 32 must not wrap.
REQ-022 In DONE, res_valid=1, and res_count/res_id hold stable until res_ready=1.
REQ-023 DONE with res_ready=1 transitions to IDLE; no request is accepted in that same cycle, so the earliest next handshake is one cycle later.
REQ-024 Requester valid changes during RUN/DONE are ignored; a requester may drop valid before it is granted, with no effect.
REQ-025 res_ready while not in DONE has no effect.
REQ-026 The latched word is unaffected by reqN_data changes after the handshake.

Reset
REQ-027 rst=1 at a clock edge forces IDLE and sets accumulator=0, idx=0, res_id=0, last_grant=1.
REQ-028 Outputs during/after reset: res_valid=0, res_count=0, busy=0, req0_ready=req1_ready=0 while rst=1.
REQ-029 Reset in RUN or DONE aborts the operation; the pending result is discarded and never presented.

Verification
REQ-030 Single req0, data=32'hFFFF_FFFF, res_ready=1 -> res_valid at N+5, res_count=32, res_id=0, then IDLE.
REQ-031 Single req1, data=32'h8000_0001 -> res_count=2, res_id=1; data=0 -> res_count=0.
REQ-032 Both valid continuously, data0=32'h0000_000F, data1=32'h00FF_0000 -> grants alternate 0,1,0,1; results 4 (id 0) and 8 (id 1) in that order.
REQ-033 res_ready held 0 for 10 cycles in DONE with data=32'h1234_5678 -> res_count=13 stable, both readys 0, busy=1; release gives IDLE next cycle.
REQ-034 rst=1 on the second RUN cycle -> next cycle IDLE, res_valid=0; the following request with data=32'h0F0F_0F0F yields 16 at N+5, with requester 0 winning contention.
